// File: rtl/div_param_pkg.sv
// Shared arithmetic-block definitions: divider FSM encoding and sizing helpers.
package div_param_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  localparam int unsigned DivDefaultBitSize = 8;

  // The iteration counter must be able to hold every value from 0 to 2*bit_size.
  function automatic int unsigned div_cnt_width(input int unsigned bit_size);
    return $clog2(2 * bit_size + 1);
  endfunction

endpackage

// File: rtl/abs_param.sv
// Combinational two's-complement magnitude and sign extraction.
// The magnitude is unsigned, so the most negative input maps to 2^(WIDTH-1).
module abs_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  // Negate only when the sign bit is set.
  always_comb begin
    neg_o = value_i[WIDTH-1];
    mag_o = neg_o ? (~value_i + WIDTH'(1)) : value_i;
  end

endmodule

// File: rtl/div_param.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit
// per clock, followed by a single sign-correction cycle.
module div_param
  import div_param_pkg::*;
#(
  parameter int unsigned BIT_SIZE = DivDefaultBitSize
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [2*BIT_SIZE-1:0] dividend,
  input  logic [BIT_SIZE-1:0]   divisor,
  output logic                  busy,
  output logic                  done,
  output logic [2*BIT_SIZE-1:0] quotient,
  output logic [BIT_SIZE-1:0]   remainder,
  output logic                  div_by_zero
);

  localparam int unsigned DW   = 2 * BIT_SIZE;
  localparam int unsigned PW   = BIT_SIZE + 1;
  localparam int unsigned CntW = div_cnt_width(BIT_SIZE);
  localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

  div_state_e state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BIT_SIZE:0]   prem_q, prem_d;     // partial remainder magnitude
  logic [DW-1:0]       dvd_q, dvd_d;       // dividend magnitude, shifts into quotient bits
  logic [BIT_SIZE-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic                neg_dvd_q, neg_dvd_d;
  logic                neg_dvs_q, neg_dvs_d;
  logic [DW-1:0]       quot_q, quot_d;
  logic [BIT_SIZE-1:0] rem_q, rem_d;
  logic                dbz_q, dbz_d;

  logic [DW-1:0]       dvd_mag;
  logic                dvd_neg;
  logic [BIT_SIZE-1:0] dvs_mag;
  logic                dvs_neg;
  logic [PW:0]         shifted;
  logic                fits;

  abs_param #(.WIDTH(DW)) u_abs_dividend (
    .value_i (dividend),
    .mag_o   (dvd_mag),
    .neg_o   (dvd_neg)
  );

  abs_param #(.WIDTH(BIT_SIZE)) u_abs_divisor (
    .value_i (divisor),
    .mag_o   (dvs_mag),
    .neg_o   (dvs_neg)
  );

  // One restoring step: bring in the next dividend bit and try to subtract the divisor.
  always_comb begin
    shifted = {prem_q, dvd_q[DW-1]};
    fits    = (shifted >= (PW + 1)'(dvs_q));
  end

  // Next-state, datapath and result update; every register holds by default.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          dvd_d     = dvd_mag;
          dvs_d     = dvs_mag;
          neg_dvd_d = dvd_neg;
          neg_dvs_d = dvs_neg;
          prem_d    = '0;
          cnt_d     = '0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        prem_d = fits ? PW'(shifted - (PW + 1)'(dvs_q)) : PW'(shifted);
        dvd_d  = {dvd_q[DW-2:0], fits};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dvs_q == '0) begin
          quot_d = '0;
          rem_d  = '0;
          dbz_d  = 1'b1;
        end else begin
          // Quotient negative when signs differ; remainder follows the dividend.
          quot_d = (neg_dvd_q ^ neg_dvs_q) ? -dvd_q : dvd_q;
          rem_d  = BIT_SIZE'(neg_dvd_q ? -prem_q : prem_q);
          dbz_d  = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state and iteration counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Working operands and partial remainder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prem_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
    end else begin
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
    end
  end

  // Published results; only written in the sign-correction cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  // Status decoded straight from state so reset clears it immediately.
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_div_param.sv
// Self-checking bench for div_param (BIT_SIZE = 8).
module tb_div_param;

  localparam int unsigned BS = 8;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     enable;
  logic signed [2*BS-1:0]   dividend;
  logic signed [BS-1:0]     divisor;
  logic                     busy;
  logic                     done;
  logic signed [2*BS-1:0]   quotient;
  logic signed [BS-1:0]     remainder;
  logic                     div_by_zero;

  int checks   = 0;
  int failures = 0;

  div_param #(.BIT_SIZE(BS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] a;
    logic signed [7:0]  b;
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic               z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer truncating division, quotient wrapped to 16 bits.
  task automatic model(input logic signed [15:0] a, input logic signed [7:0] b,
                       output logic signed [15:0] q, output logic signed [7:0] r,
                       output logic z);
    longint la, lb, lq, lr;
    la = a;
    lb = b;
    if (lb == 0) begin
      q = '0;
      r = '0;
      z = 1'b1;
    end else begin
      lq = la / lb;
      lr = la % lb;
      q  = lq[15:0];
      r  = lr[7:0];
      z  = 1'b0;
    end
  endtask

  // One complete operation; optional disturbance (re-enable + new operands) mid-run.
  task automatic run_op(input logic signed [15:0] a, input logic signed [7:0] b,
                        input logic signed [15:0] eq, input logic signed [7:0] er,
                        input logic ez, input bit disturb, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    enable   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    chk({tag, " busy_after_accept"}, busy, 1);
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (disturb && k == 5) begin
        enable   = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (disturb && k == 5) enable = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " latency"}, seen ? k : -1, 17);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_drop"}, done, 0);
    chk({tag, " busy_drop"}, busy, 0);
    chk({tag, " quotient_hold"}, quotient, eq);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] mq, ra;
    logic signed [7:0]  mr, rb;
    logic               mz;
    logic signed [15:0] bq[3];
    logic signed [7:0]  br[3];
    logic               bz[3];
    bit                 sd;
    int                 prev, ndone;
    bit                 have_last;
    logic signed [15:0] last_q;
    logic signed [7:0]  last_r;

    vecs[0] = '{16'sd100, 8'sd7, 16'sd14, 8'sd2, 1'b0};
    vecs[1] = '{-16'sd100, 8'sd7, -16'sd14, -8'sd2, 1'b0};
    vecs[2] = '{16'sd100, -8'sd7, -16'sd14, 8'sd2, 1'b0};
    vecs[3] = '{-16'sd100, -8'sd7, 16'sd14, -8'sd2, 1'b0};
    vecs[4] = '{16'sh8000, -8'sd1, 16'sh8000, 8'sd0, 1'b0};
    vecs[5] = '{16'sd5, 8'sd0, 16'sd0, 8'sd0, 1'b1};
    vecs[6] = '{16'sh8000, 8'sh80, 16'sd256, 8'sd0, 1'b0};
    vecs[7] = '{16'sd32767, 8'sh80, -16'sd255, 8'sd127, 1'b0};
    vecs[8] = '{16'sh8000, 8'sd127, -16'sd258, -8'sd2, 1'b0};
    vecs[9] = '{16'sd0, 8'sd5, 16'sd0, 8'sd0, 1'b0};

    reset_n  = 1'b1;
    enable   = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table, including sign combinations, overflow and zero divisor.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, (i % 3) == 1,
             $sformatf("vec%0d", i));
    end

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'($signed(8'($urandom)));
      model(ra, rb, mq, mr, mz);
      run_op(ra, rb, mq, mr, mz, $urandom_range(0, 1) == 1, $sformatf("rnd%0d", i));
    end

    // Abort mid-calculation: ignored re-enable, then asynchronous reset.
    run_op(16'sd100, 8'sd7, 16'sd14, 8'sd2, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    dividend = 16'sd1000;
    divisor  = 8'sd3;
    enable   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    sd = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin
        enable   = 1'b1;
        dividend = 16'sd77;
        divisor  = 8'sd5;
      end
      @(posedge clk);
      #1;
      if (done) sd = 1'b1;
      if (k == 5) enable = 1'b0;
      if (k == 9) chk("abort busy_before_reset", busy, 1);
    end
    reset_n = 1'b0;
    #1;
    chk("abort no_done_pulse", sd, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(16'sd1000, 8'sd3, 16'sd333, 8'sd1, 1'b0, 1'b0, "post_abort");

    // Back-to-back with enable held high.
    model(16'sd100, 8'sd7, bq[0], br[0], bz[0]);
    model(16'sd1000, 8'sd3, bq[1], br[1], bz[1]);
    model(-16'sd100, 8'sd7, bq[2], br[2], bz[2]);
    @(negedge clk);
    dividend  = 16'sd100;
    divisor   = 8'sd7;
    enable    = 1'b1;
    prev      = 0;
    ndone     = 0;
    have_last = 1'b0;
    last_q    = '0;
    last_r    = '0;
    for (int e = 1; e <= 70; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        chk($sformatf("b2b spacing%0d", ndone), e - prev, (ndone == 1) ? 18 : 19);
        prev = e;
        if (ndone <= 3) begin
          chk($sformatf("b2b quotient%0d", ndone), quotient, bq[ndone-1]);
          chk($sformatf("b2b remainder%0d", ndone), remainder, br[ndone-1]);
          chk($sformatf("b2b div_by_zero%0d", ndone), div_by_zero, bz[ndone-1]);
        end
        last_q    = quotient;
        last_r    = remainder;
        have_last = 1'b1;
        if (ndone == 1) begin
          dividend = 16'sd1000;
          divisor  = 8'sd3;
        end else if (ndone == 2) begin
          dividend = -16'sd100;
          divisor  = 8'sd7;
        end
      end else if (have_last) begin
        chk($sformatf("b2b hold_q e%0d", e), quotient, last_q);
        chk($sformatf("b2b hold_r e%0d", e), remainder, last_r);
      end
    end
    chk("b2b done_count", ndone, 3);
    enable = 1'b0;
    repeat (25) @(negedge clk);
    chk("b2b idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
